// File: rtl/pwm_multi_duty.sv
// -----------------------------------------------------------------------------
// pwm_multi_duty
//
// Multi-channel PWM generator. A single period counter is shared by NCH
// duty comparators. Each channel has its own duty value and output polarity.
// The counter runs either edge-aligned (0..P, then wrap) or centre-aligned
// (0..P..1, then back to 0). All configuration goes through shadow registers
// and is only promoted to the active set at a period boundary, or while the
// generator is idle. This means a running waveform never sees a partially
// updated configuration.
//
// Parameters
//   CNT_W  width of the counter, period and duty values
//   NCH    number of PWM channels
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   en           1 = counter runs, 0 = counter parked at 0 and outputs idle
//   load         1-cycle strobe that captures the *_in values
//   period_in    terminal count P
//   duty_in      per-channel duty, channel i at [i*CNT_W +: CNT_W]
//   mode_in      0 = edge-aligned, 1 = centre-aligned
//   pol_in       per-channel polarity, 1 inverts the output
//   pwm_out      registered PWM outputs
//   period_tick  1-cycle pulse in the cycle whose output reflects cnt == 0
//   upd_ack      1-cycle pulse when new configuration becomes active
// -----------------------------------------------------------------------------
module pwm_multi_duty #(
  parameter int CNT_W = 8,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 load,
  input  logic [CNT_W-1:0]     period_in,
  input  logic [NCH*CNT_W-1:0] duty_in,
  input  logic                 mode_in,
  input  logic [NCH-1:0]       pol_in,
  output logic [NCH-1:0]       pwm_out,
  output logic                 period_tick,
  output logic                 upd_ack
);

  localparam logic DIR_UP      = 1'b0;
  localparam logic DIR_DOWN    = 1'b1;
  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTRE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] PERIOD_RST = '1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 dir_q, dir_d;

  logic [CNT_W-1:0]     act_period_q, act_period_d;
  logic [NCH*CNT_W-1:0] act_duty_q,   act_duty_d;
  logic                 act_mode_q,   act_mode_d;
  logic [NCH-1:0]       act_pol_q,    act_pol_d;

  logic [CNT_W-1:0]     sh_period_q,  sh_period_d;
  logic [NCH*CNT_W-1:0] sh_duty_q,    sh_duty_d;
  logic                 sh_mode_q,    sh_mode_d;
  logic [NCH-1:0]       sh_pol_q,     sh_pol_d;
  logic                 pending_q,    pending_d;

  logic [NCH-1:0]       pwm_q,        pwm_d;
  logic                 tick_q,       tick_d;
  logic                 ack_q,        ack_d;

  // ---------------------------------------------------------------------------
  // Free-running counter successor (ignores en and configuration updates)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_run;
  logic             dir_run;

  always_comb begin
    cnt_run = CNT_ZERO;
    dir_run = DIR_UP;
    if (act_mode_q == MODE_EDGE) begin
      // The >= test (rather than ==) keeps the counter bounded even if cnt
      // were ever above P. Updates only land at cnt 0, so this cannot occur
      // in normal operation.
      if (cnt_q >= act_period_q) begin
        cnt_run = CNT_ZERO;
      end else begin
        cnt_run = cnt_q + CNT_ONE;
      end
    end else if (act_period_q == CNT_ZERO) begin
      cnt_run = CNT_ZERO;
      dir_run = DIR_UP;
    end else if (dir_q == DIR_UP) begin
      if (cnt_q >= act_period_q) begin
        // Turn around at the top. With P == 1 the next value is already 0,
        // so the direction goes straight back to up.
        cnt_run = cnt_q - CNT_ONE;
        dir_run = (cnt_run == CNT_ZERO) ? DIR_UP : DIR_DOWN;
      end else begin
        cnt_run = cnt_q + CNT_ONE;
        dir_run = DIR_UP;
      end
    end else begin
      if (cnt_q == CNT_ZERO) begin
        cnt_run = CNT_ZERO;
      end else begin
        cnt_run = cnt_q - CNT_ONE;
      end
      dir_run = (cnt_run == CNT_ZERO) ? DIR_UP : DIR_DOWN;
    end
  end

  // ---------------------------------------------------------------------------
  // Update arbitration
  // ---------------------------------------------------------------------------
  // Idle cycles (en == 0) are treated like period boundaries. A pending
  // shadow is promoted at once, and a load seen while idle is applied
  // directly, the same as a load in a terminal cycle.
  logic terminal;
  logic upd_now;
  logic apply_in;
  logic apply_sh;

  always_comb begin
    terminal = en && (cnt_run == CNT_ZERO);
    upd_now  = terminal || !en;
    apply_in = upd_now && load;
    apply_sh = upd_now && !load && pending_q;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d        = en ? cnt_run : CNT_ZERO;
    dir_d        = en ? dir_run : DIR_UP;

    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    act_mode_d   = act_mode_q;
    act_pol_d    = act_pol_q;

    sh_period_d  = sh_period_q;
    sh_duty_d    = sh_duty_q;
    sh_mode_d    = sh_mode_q;
    sh_pol_d     = sh_pol_q;
    pending_d    = pending_q;

    // A later load simply overwrites the shadow, so the last one wins.
    if (load) begin
      sh_period_d = period_in;
      sh_duty_d   = duty_in;
      sh_mode_d   = mode_in;
      sh_pol_d    = pol_in;
      pending_d   = 1'b1;
    end

    if (apply_in) begin
      act_period_d = period_in;
      act_duty_d   = duty_in;
      act_mode_d   = mode_in;
      act_pol_d    = pol_in;
      pending_d    = 1'b0;
    end else if (apply_sh) begin
      act_period_d = sh_period_q;
      act_duty_d   = sh_duty_q;
      act_mode_d   = sh_mode_q;
      act_pol_d    = sh_pol_q;
      pending_d    = 1'b0;
    end

    // Every new configuration starts its first period from the bottom.
    if (apply_in || apply_sh) begin
      cnt_d = CNT_ZERO;
      dir_d = DIR_UP;
    end
  end

  // ---------------------------------------------------------------------------
  // Output compare. The values come from the current (pre-update) count and
  // active set, so an update never truncates the pulse of the closing period.
  // ---------------------------------------------------------------------------
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NCH; i++) begin
      pwm_d[i] = act_pol_q[i] ^ (en && (cnt_q < act_duty_q[i*CNT_W +: CNT_W]));
    end
    tick_d = en && (cnt_q == CNT_ZERO) &&
             ((dir_q == DIR_UP) || (act_period_q == CNT_ZERO));
    ack_d  = apply_in || apply_sh;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= CNT_ZERO;
      dir_q        <= DIR_UP;
      act_period_q <= PERIOD_RST;
      act_duty_q   <= '0;
      act_mode_q   <= MODE_EDGE;
      act_pol_q    <= '0;
      sh_period_q  <= PERIOD_RST;
      sh_duty_q    <= '0;
      sh_mode_q    <= MODE_EDGE;
      sh_pol_q     <= '0;
      pending_q    <= 1'b0;
      pwm_q        <= '0;
      tick_q       <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      act_mode_q   <= act_mode_d;
      act_pol_q    <= act_pol_d;
      sh_period_q  <= sh_period_d;
      sh_duty_q    <= sh_duty_d;
      sh_mode_q    <= sh_mode_d;
      sh_pol_q     <= sh_pol_d;
      pending_q    <= pending_d;
      pwm_q        <= pwm_d;
      tick_q       <= tick_d;
      ack_q        <= ack_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = tick_q;
  assign upd_ack     = ack_q;

endmodule

// File: doc/pwm_multi_duty.md
Name: pwm_multi_duty

Overview:
Parametrised multi-channel PWM generator; successor to the fixed 20% divide-by-10 duty block. One shared period counter drives NCH comparators, each with its own programmable duty and output polarity. Counting is edge-aligned (up, wrap) or centre-aligned (up/down). Configuration is double-buffered, so updates take effect only at a period boundary and never produce glitched pulses.

Parameters:
CNT_W, 8, width of the counter, period and duty values
NCH, 4, number of PWM channels

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-low; 0 clears all state immediately
en  input  1  1 = counter runs; 0 = counter held at 0, outputs idle
load  input  1  1-cycle strobe that captures the *_in values into shadow registers
period_in  input  CNT_W  terminal count P (edge: period P+1 cycles; centre: 2P cycles)
duty_in  input  NCH*CNT_W  per-channel duty D[i], channel i at bits [i*CNT_W +: CNT_W]
mode_in  input  1  0 = edge-aligned, 1 = centre-aligned
pol_in  input  NCH  per-channel polarity; 1 inverts the output
pwm_out  output  NCH  registered PWM outputs
period_tick  output  1  1-cycle pulse marking the start of each period
upd_ack  output  1  1-cycle pulse when shadow values become active

Behaviour:
- Reset (rst=0, asynchronous):
  - cnt=0, dir=up.
  - Active period = 2^CNT_W-1; active duties = 0; mode = edge; pol = 0.
  - Shadow pending flag cleared.
  - pwm_out=0, period_tick=0, upd_ack=0.
- Release is synchronous to clk.
- Edge mode: cnt runs 0,1,…,P,0,… ; dir is unused.
- Centre mode:
  - cnt runs 0,1,…,P,P-1,…,1,0,…
  - dir flips to down when cnt==P and back to up when the next value is 0.
- P=0 in either mode: cnt stays 0.
- Terminal cycle: any running cycle (en=1) in which the next cnt value is 0. With P=0, every cycle is terminal.
- Output latency is 1 cycle. For each channel, at every edge: pwm_out[i] <= pol[i] XOR (en AND cnt < D[i]).
  - Edge mode high time per period: min(D,P+1) cycles. D=0 gives constant low; D>P gives constant high.
  - Centre mode high time per period: 0 if D=0; 2D-1 if 1≤D≤P; 2P if D>P. The pulse is centred on cnt==0.
- period_tick <= en AND (cnt==0) AND (first cycle of a period, i.e. dir==up or P==0). It is asserted in the same cycle that pwm_out reflects cnt==0.
- Shadow update:
  - load=1 copies period_in, duty_in, mode_in and pol_in into the shadow registers and sets pending.
  - A second load before the update overwrites the shadow registers; the last one wins.
  - On a terminal cycle with pending=1, the shadow values are copied to the active registers at that edge. The next period then starts at cnt=0, dir=up, with the new values. pending clears and upd_ack pulses for 1 cycle.
  - load coincident with a terminal cycle: the values on *_in are applied directly at that edge, and upd_ack pulses.
  - en=0 with pending=1: the shadow is applied at the next edge; upd_ack pulses.
- en=0: cnt is forced to 0 and dir to up at the next edge. pwm_out goes to pol, which is the idle level. period_tick=0.
- en 0->1: counting starts from cnt=0. The first period_tick appears one cycle after en rises.
- Period change to P' < current cnt mid-period: no effect until the terminal cycle. The current period completes with the old P.
- Reset asserted mid-period: all outputs clear immediately; pending loads are discarded.
- All compares are unsigned CNT_W-bit. Counter arithmetic never exceeds P, so no overflow is possible.

Test Plan:
- Reset: rst=0 at an arbitrary time -> pwm_out=0, period_tick=0, upd_ack=0 within the same cycle; after release with en=1, the default period is 256 cycles.
- Edge 20%: load P=9, D[0]=2, D[1]=5, D[2]=0, D[3]=15, pol=0, mode=0, then en=1 -> period 10 cycles. Ch0 high 2 of 10, ch1 high 5 of 10, ch2 always 0, ch3 always 1. period_tick every 10 cycles.
- Centre mode: load P=4, D[0]=2, mode=1 -> period 8 cycles. Ch0 high 3 consecutive cycles centred on cnt==0. period_tick every 8 cycles.
- Double-buffer: mid-period at cnt=3 (P=9), load P=4, D[0]=1 -> the old period completes to cnt=9. upd_ack coincides with the next cnt==0. The new period is 5 cycles with ch0 high 1 cycle. No runt pulse.
- Simultaneous events: load asserted in the terminal cycle -> new values are active from the next cnt=0. A back-to-back double load -> only the second set is applied, with a single upd_ack.
- Enable/polarity: pol[1]=1 with en=0 -> pwm_out[1]=1, cnt=0, no ticks. en=1 -> the inverted waveform starts. Drop en mid-period -> outputs return to pol within 1 cycle.
